// File: rtl/pcie_tl_pkg.sv
// Shared PCIe transaction-layer definitions: one-hot control states and default widths.
// Imported by the control FSM, the per-port packet counters and the FIFO bank.
package pcie_tl_pkg;

  localparam int STATE_W      = 5;
  localparam int UMBRAL_W_DEF = 3;

  // Bits [3:0] match the encoding the counters already decode; bit 4 is ERROR.
  localparam logic [STATE_W-1:0] ST_RESET  = 5'b00001;
  localparam logic [STATE_W-1:0] ST_INIT   = 5'b00010;
  localparam logic [STATE_W-1:0] ST_IDLE   = 5'b00100;
  localparam logic [STATE_W-1:0] ST_ACTIVE = 5'b01000;
  localparam logic [STATE_W-1:0] ST_ERROR  = 5'b10000;

  typedef enum logic [STATE_W-1:0] {
    TL_RESET  = ST_RESET,
    TL_INIT   = ST_INIT,
    TL_IDLE   = ST_IDLE,
    TL_ACTIVE = ST_ACTIVE,
    TL_ERROR  = ST_ERROR
  } tl_state_e;

endpackage

// File: rtl/pcie_tl_fsm_if.sv
// Control/status bundle between the transaction-layer FSM (slave side) and its
// environment: FIFO flags and threshold candidates in, one-hot state and latched thresholds out.
interface pcie_tl_fsm_if
  import pcie_tl_pkg::*;
#(
  parameter int NUM_FIFOS = 8,
  parameter int UMBRAL_W  = UMBRAL_W_DEF
);
  logic                 init;
  logic [UMBRAL_W-1:0]  umbral_superior_in;
  logic [UMBRAL_W-1:0]  umbral_inferior_in;
  logic [NUM_FIFOS-1:0] fifo_empty;
  logic [NUM_FIFOS-1:0] fifo_error;
  logic [STATE_W-1:0]   state;
  logic [STATE_W-1:0]   next_state;
  logic [UMBRAL_W-1:0]  umbral_superior;
  logic [UMBRAL_W-1:0]  umbral_inferior;
  logic                 idle_out;
  logic                 error_out;
  logic [NUM_FIFOS-1:0] error_fifo;

  modport master (
    output init, umbral_superior_in, umbral_inferior_in, fifo_empty, fifo_error,
    input  state, next_state, umbral_superior, umbral_inferior, idle_out, error_out, error_fifo
  );

  modport slave (
    input  init, umbral_superior_in, umbral_inferior_in, fifo_empty, fifo_error,
    output state, next_state, umbral_superior, umbral_inferior, idle_out, error_out, error_fifo
  );
endinterface

// File: rtl/pcie_tl_fsm_idle_timer.sv
// Saturating counter of consecutive all-empty cycles; expired flags the cycle whose
// sample completes the IDLE_CYCLES-long run, so the FSM can leave ACTIVE on that edge.
module idle_timer #(
  parameter int IDLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_L,
  input  logic clear,
  input  logic tick,
  output logic expired
);
  localparam int            CW   = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] MAX  = CW'(IDLE_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)                cnt <= '0;
    else if (clear)              cnt <= '0;
    else if (tick && cnt != MAX) cnt <= cnt + 1'b1;
  end

  assign expired = tick && (cnt >= LAST);

endmodule

// File: rtl/pcie_tl_fsm.sv
// PCIe transaction-layer control FSM: RESET -> INIT -> IDLE/ACTIVE, threshold latching in INIT,
// sticky ERROR on any FIFO error pulse when PCIE_TL_FSM_ERROR_EN is defined.
module pcie_tl_fsm
  import pcie_tl_pkg::*;
#(
  parameter int NUM_FIFOS   = 8,
  parameter int UMBRAL_W    = UMBRAL_W_DEF,
  parameter int IDLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  pcie_tl_fsm_if.slave  bus
);

  tl_state_e            state_q, nxt;
  logic [UMBRAL_W-1:0]  sup_q, inf_q;
  logic                 idle_q;
  logic                 all_empty, err_hit;
  logic                 tick, tclr, expired;

  assign all_empty = &bus.fifo_empty;

`ifdef PCIE_TL_FSM_ERROR_EN
  logic                 err_q;
  logic [NUM_FIFOS-1:0] efifo_q;
  assign err_hit = |bus.fifo_error;
`else
  logic unused_fifo_error;
  assign err_hit           = 1'b0;
  assign unused_fifo_error = ^bus.fifo_error;
`endif

  always_comb begin
    nxt = state_q;
    if (!reset_L) nxt = TL_INIT;
    else begin
      case (state_q)
        TL_RESET:  nxt = TL_INIT;
        TL_INIT:   if (!bus.init && inf_q < sup_q) nxt = TL_IDLE;
        TL_IDLE: begin
          if (err_hit)         nxt = TL_ERROR;
          else if (bus.init)   nxt = TL_INIT;
          else if (!all_empty) nxt = TL_ACTIVE;
        end
        TL_ACTIVE: begin
          if (err_hit)       nxt = TL_ERROR;
          else if (bus.init) nxt = TL_INIT;
          else if (expired)  nxt = TL_IDLE;
        end
        TL_ERROR:  nxt = TL_ERROR;
        default:   nxt = TL_RESET;
      endcase
    end
  end

  // Run restarts on any non-empty cycle, outside ACTIVE, and on every state change.
  assign tick = (state_q == TL_ACTIVE) && all_empty;
  assign tclr = !tick || (nxt != state_q);

  idle_timer #(.IDLE_CYCLES(IDLE_CYCLES)) u_idle_timer (
    .clk     (clk),
    .reset_L (reset_L),
    .clear   (tclr),
    .tick    (tick),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= TL_RESET;
      sup_q   <= '0;
      inf_q   <= '0;
      idle_q  <= 1'b0;
`ifdef PCIE_TL_FSM_ERROR_EN
      err_q   <= 1'b0;
      efifo_q <= '0;
`endif
    end else begin
      state_q <= nxt;
      idle_q  <= (nxt == TL_IDLE);
      if (state_q == TL_INIT && bus.init) begin
        sup_q <= bus.umbral_superior_in;
        inf_q <= bus.umbral_inferior_in;
      end
`ifdef PCIE_TL_FSM_ERROR_EN
      err_q <= (nxt == TL_ERROR);
      if (nxt == TL_ERROR && state_q != TL_ERROR) efifo_q <= bus.fifo_error;
`endif
    end
  end

  assign bus.umbral_superior = sup_q;
  assign bus.umbral_inferior = inf_q;
  assign bus.idle_out        = idle_q;

`ifdef PCIE_TL_FSM_ERROR_EN
  assign bus.state      = state_q;
  assign bus.next_state = nxt;
  assign bus.error_out  = err_q;
  assign bus.error_fifo = efifo_q;
`else
  assign bus.state      = {1'b0, state_q[STATE_W-2:0]};
  assign bus.next_state = {1'b0, nxt[STATE_W-2:0]};
  assign bus.error_out  = 1'b0;
  assign bus.error_fifo = '0;
`endif

endmodule

// File: tb/tb_pcie_tl_fsm.sv
// Bench for pcie_tl_fsm: directed walk through the bring-up/idle/error scenarios, then
// randomized traffic against a cycle-level behavioural model of the state rules.
module tb_pcie_tl_fsm;

  localparam int NF = 8, UW = 3, IC = 4;
`ifdef PCIE_TL_FSM_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [4:0] M_RST = 5'b00001, M_INI = 5'b00010, M_IDL = 5'b00100,
                         M_ACT = 5'b01000, M_ERR = 5'b10000;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  pcie_tl_fsm_if #(.NUM_FIFOS(NF), .UMBRAL_W(UW)) bus ();

  pcie_tl_fsm #(.NUM_FIFOS(NF), .UMBRAL_W(UW), .IDLE_CYCLES(IC)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  int nchk = 0, nerr = 0;

  logic [4:0]    m_st;
  logic [UW-1:0] m_sup, m_inf;
  logic [NF-1:0] m_ef;
  int            m_run;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] m_next(bit ini, logic [NF-1:0] emp, logic [NF-1:0] err);
    bit e = ERR_EN && (err != '0);
    bit full_run = (emp == '1) && (m_run + 1 >= IC);
    case (m_st)
      M_RST: return M_INI;
      M_INI: return (!ini && m_inf < m_sup) ? M_IDL : M_INI;
      M_IDL: return e ? M_ERR : ini ? M_INI : (emp != '1) ? M_ACT : M_IDL;
      M_ACT: return e ? M_ERR : ini ? M_INI : full_run ? M_IDL : M_ACT;
      M_ERR: return M_ERR;
      default: return M_RST;
    endcase
  endfunction

  task automatic m_reset();
    m_st = M_RST; m_sup = '0; m_inf = '0; m_ef = '0; m_run = 0;
  endtask

  task automatic check_outs();
    chk("state", {27'b0, bus.state}, {27'b0, m_st});
    chk("umb_sup", {29'b0, bus.umbral_superior}, {29'b0, m_sup});
    chk("umb_inf", {29'b0, bus.umbral_inferior}, {29'b0, m_inf});
    chk("idle_out", {31'b0, bus.idle_out}, {31'b0, m_st == M_IDL});
    chk("error_out", {31'b0, bus.error_out}, {31'b0, m_st == M_ERR});
    chk("error_fifo", {24'b0, bus.error_fifo}, {24'b0, m_ef});
  endtask

  // One clock: drive at negedge, check next_state, take the edge, advance model, check outputs.
  task automatic cycle(bit ini, logic [UW-1:0] sup, logic [UW-1:0] inf,
                       logic [NF-1:0] emp, logic [NF-1:0] err);
    logic [4:0] nxt;
    @(negedge clk);
    bus.init = ini; bus.umbral_superior_in = sup; bus.umbral_inferior_in = inf;
    bus.fifo_empty = emp; bus.fifo_error = err;
    #1;
    nxt = m_next(ini, emp, err);
    chk("next_state", {27'b0, bus.next_state}, {27'b0, nxt});
    @(posedge clk);
    if (m_st == M_INI && ini) begin m_sup = sup; m_inf = inf; end
    if (nxt == M_ERR && m_st != M_ERR) m_ef = err;
    if (nxt != m_st || m_st != M_ACT || emp != '1) m_run = 0;
    else m_run++;
    m_st = nxt;
    #1;
    check_outs();
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_state"}, {27'b0, bus.state}, 32'h01);
    chk({tag, "_next"}, {27'b0, bus.next_state}, 32'h02);
    chk({tag, "_umb"}, {26'b0, bus.umbral_superior, bus.umbral_inferior}, 32'h0);
    chk({tag, "_flags"}, {30'b0, bus.idle_out, bus.error_out}, 32'h0);
    chk({tag, "_efifo"}, {24'b0, bus.error_fifo}, 32'h0);
  endtask

  // Called just after a rising edge: pulse reset between edges and check it bites at once.
  task automatic async_rst();
    #1 reset_L = 1'b0;
    #1 check_reset_vals("arst");
    m_reset();
    #1 reset_L = 1'b1;
  endtask

  task automatic bring_up_active();
    cycle(1'b1, 3'd6, 3'd1, 8'hFF, 8'h00);
    cycle(1'b1, 3'd6, 3'd1, 8'hFF, 8'h00);
    cycle(1'b0, 3'd0, 3'd0, 8'hFF, 8'h00);
    cycle(1'b0, 3'd0, 3'd0, 8'hFE, 8'h00);
    chk("up_active", {27'b0, bus.state}, {27'b0, M_ACT});
  endtask

  initial begin
    logic [NF-1:0] emp, err;
    bus.init = 1'b0; bus.umbral_superior_in = '0; bus.umbral_inferior_in = '0;
    bus.fifo_empty = '1; bus.fifo_error = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_vals("rst");
    reset_L = 1'b1;

    // Bring-up with valid thresholds 6/1
    cycle(1'b1, 3'd6, 3'd1, 8'hFF, 8'h00);
    chk("d_init", {27'b0, bus.state}, 32'h02);
    cycle(1'b1, 3'd6, 3'd1, 8'hFF, 8'h00);
    cycle(1'b0, 3'd0, 3'd0, 8'hFF, 8'h00);
    chk("d_idle", {27'b0, bus.state}, 32'h04);
    chk("d_umb", {26'b0, bus.umbral_superior, bus.umbral_inferior}, {26'b0, 3'd6, 3'd1});

    // Invalid thresholds keep INIT; a valid init pulse then releases to IDLE
    cycle(1'b1, 3'd2, 3'd5, 8'hFF, 8'h00);
    cycle(1'b1, 3'd2, 3'd5, 8'hFF, 8'h00);
    repeat (5) cycle(1'b0, 3'd7, 3'd0, 8'hFF, 8'h00);
    chk("d_bad_umb", {27'b0, bus.state}, 32'h02);
    chk("d_bad_keep", {26'b0, bus.umbral_superior, bus.umbral_inferior}, {26'b0, 3'd2, 3'd5});
    cycle(1'b1, 3'd7, 3'd3, 8'hFF, 8'h00);
    cycle(1'b0, 3'd0, 3'd0, 8'hFF, 8'h00);
    chk("d_idle2", {27'b0, bus.state}, 32'h04);

    // ACTIVE, interrupted empty run, then a full IC-long run back to IDLE
    cycle(1'b0, 3'd0, 3'd0, 8'hFE, 8'h00);
    chk("d_active", {27'b0, bus.state}, 32'h08);
    repeat (3) cycle(1'b0, 3'd0, 3'd0, 8'hFF, 8'h00);
    cycle(1'b0, 3'd0, 3'd0, 8'hEF, 8'h00);
    repeat (3) cycle(1'b0, 3'd0, 3'd0, 8'hFF, 8'h00);
    chk("d_run3", {27'b0, bus.state}, 32'h08);
    cycle(1'b0, 3'd0, 3'd0, 8'hFF, 8'h00);
    chk("d_run4", {27'b0, bus.state}, 32'h04);
    cycle(1'b0, 3'd0, 3'd0, 8'hFE, 8'h00);

`ifdef PCIE_TL_FSM_ERROR_EN
    cycle(1'b1, 3'd0, 3'd0, 8'hFE, 8'h20);
    chk("d_err", {27'b0, bus.state}, 32'h10);
    chk("d_efifo", {24'b0, bus.error_fifo}, 32'h20);
    repeat (3) cycle(1'b1, 3'd0, 3'd0, 8'hFE, 8'h01);
    chk("d_err_sticky", {27'b0, bus.state}, 32'h10);
    chk("d_efifo_hold", {24'b0, bus.error_fifo}, 32'h20);
    async_rst();
    bring_up_active();
`else
    cycle(1'b0, 3'd0, 3'd0, 8'hFE, 8'h20);
    chk("d_noerr", {27'b0, bus.state}, 32'h08);
    chk("d_noerr_out", {24'b0, bus.error_fifo}, {31'b0, bus.error_out});
    chk("d_noerr_efifo", {24'b0, bus.error_fifo}, 32'h0);
`endif
    async_rst();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) async_rst();
      else begin
        emp = ($urandom_range(0, 3) == 0) ? NF'($urandom) : '1;
        err = ($urandom_range(0, 79) == 0) ? NF'($urandom_range(1, 255)) : '0;
        cycle($urandom_range(0, 9) == 0, UW'($urandom), UW'($urandom), emp, err);
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
